// File: rtl/b16_mem_pkg.sv
// Shared definitions for the b16 external SRAM arbiter.
//   state_t        : arbiter FSM states
//   PORT_DBG/CPU   : requester index constants (bit positions in gnt)
//   WAIT_DEFAULT   : default number of ACCESS cycles
//   STARVE_DEFAULT : default debug grants tolerated while the CPU waits
//   req_valid()    : a request is only real when it reads or writes something
package b16_mem_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam int PORT_DBG       = 0;
  localparam int PORT_CPU       = 1;
  localparam int WAIT_DEFAULT   = 3;
  localparam int STARVE_DEFAULT = 4;
  localparam int DATA_W         = 16;

  function automatic logic req_valid(input logic req, input logic r, input logic [1:0] w);
    return req & (r | (|w));
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// One requester port of the SRAM arbiter.
//   master : requester side (drives req/addr/r/w/wdata, receives ack/rdata)
//   slave  : arbiter side
// req is held until ack; ack is a single-cycle pulse; rdata is held until
// the next read on the same port completes.
interface sram_arbiter_if;
  import b16_mem_pkg::*;

  logic              req;
  logic [15:0]       addr;
  logic              r;
  logic [1:0]        w;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, r, w, wdata, input ack, rdata);
  modport slave  (input req, addr, r, w, wdata, output ack, rdata);
endinterface

// File: rtl/sram_grant_sel.sv
// Priority / anti-starvation picker for the two SRAM requesters.
//   clk, reset : clock and synchronous active-high reset
//   arb_en     : arbiter is in IDLE and may grant this cycle
//   dbg_vld    : debug port has a valid request
//   cpu_vld    : CPU port has a valid request
//   sel_dbg    : debug granted this cycle
//   sel_cpu    : CPU granted this cycle
// Debug wins by default; the CPU wins when debug is idle or after STARVE
// consecutive debug grants taken while the CPU was waiting.
module sram_grant_sel #(
  parameter int STARVE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic dbg_vld,
  input  logic cpu_vld,
  output logic sel_dbg,
  output logic sel_cpu
);

  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  logic [SW-1:0] starve_cnt;
  logic          cpu_force;

  assign cpu_force = (starve_cnt == STARVE_MAX);
  assign sel_cpu   = arb_en & cpu_vld & (~dbg_vld | cpu_force);
  assign sel_dbg   = arb_en & dbg_vld & ~sel_cpu;

  // Only arbitration cycles move the counter; a CPU that is not asking
  // at that moment has nothing to be starved of.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!cpu_vld || sel_cpu)
        starve_cnt <= '0;
      else if (sel_dbg && !cpu_force)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and timing sequencer for the b16 external 16-bit async SRAM.
//   clk, reset      : clock and synchronous active-high reset
//   dbg, cpu        : requester ports (sram_arbiter_if.slave)
//   busy            : an access is in progress (state != IDLE)
//   gnt             : one-hot owner {cpu, dbg}, 00 when idle
//   sram_addr       : word address {2'b00, addr[15:1]}
//   sram_dq_in      : pad input data
//   sram_dq_out     : write data to pads; sram_dq_oe enables the pad drivers
//   sram_*_n        : active-low SRAM strobes
// Each access is IDLE -> SETUP -> ACCESS x WAIT -> DONE -> IDLE; all outputs
// are registered from the next-state decode so they line up with the state.
module sram_arbiter
  import b16_mem_pkg::*;
#(
  parameter int WAIT   = WAIT_DEFAULT,
  parameter int STARVE = STARVE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  sram_arbiter_if.slave     dbg,
  sram_arbiter_if.slave     cpu,
  output logic              busy,
  output logic [1:0]        gnt,
  output logic [17:0]       sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT - 1);

  state_t     state, state_d;
  logic [3:0] wait_cnt;
  logic       own_cpu_q, wr_q;
  logic [1:0] be_q;
  logic       own_cpu_n, wr_n;
  logic [1:0] be_n;
  logic       dbg_vld, cpu_vld, sel_dbg, sel_cpu, load, capture;
  logic       active_d, busy_d, ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d;
  logic       dbg_ack_d, cpu_ack_d;
  logic [1:0] gnt_d;
  logic       addr_lsb_unused;

  assign addr_lsb_unused = dbg.addr[0] ^ cpu.addr[0];

  assign dbg_vld = req_valid(dbg.req, dbg.r, dbg.w);
  assign cpu_vld = req_valid(cpu.req, cpu.r, cpu.w);
  assign load    = sel_dbg | sel_cpu;
  assign capture = (state == ACCESS) && (wait_cnt == WAIT_LAST) && !wr_q;

  sram_grant_sel #(.STARVE(STARVE)) u_sel (
    .clk     (clk),
    .reset   (reset),
    .arb_en  (state == IDLE),
    .dbg_vld (dbg_vld),
    .cpu_vld (cpu_vld),
    .sel_dbg (sel_dbg),
    .sel_cpu (sel_cpu)
  );

  // Next state
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (load) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (wait_cnt == WAIT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state and the owner about to be latched;
  // a write with r also set is still a write.
  always_comb begin
    own_cpu_n = own_cpu_q;
    wr_n      = wr_q;
    be_n      = be_q;
    if (load) begin
      own_cpu_n = sel_cpu;
      wr_n      = sel_cpu ? (|cpu.w) : (|dbg.w);
      be_n      = sel_cpu ? cpu.w : dbg.w;
    end
    active_d  = (state_d != IDLE);
    busy_d    = active_d;
    gnt_d     = active_d ? {own_cpu_n, ~own_cpu_n} : 2'b00;
    ce_n_d    = ~active_d;
    oe_n_d    = ~(active_d && !wr_n && state_d != DONE);
    we_n_d    = ~(state_d == ACCESS && wr_n);
    dq_oe_d   = active_d && wr_n;
    ub_n_d    = ~active_d | (wr_n & ~be_n[1]);
    lb_n_d    = ~active_d | (wr_n & ~be_n[0]);
    dbg_ack_d = (state_d == DONE) && !own_cpu_n;
    cpu_ack_d = (state_d == DONE) &&  own_cpu_n;
  end

  // State, strobes and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      own_cpu_q   <= 1'b0;
      wr_q        <= 1'b0;
      busy        <= 1'b0;
      gnt         <= 2'b00;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      dbg.ack     <= 1'b0;
      cpu.ack     <= 1'b0;
      dbg.rdata   <= '0;
      cpu.rdata   <= '0;
    end else begin
      state      <= state_d;
      wait_cnt   <= (state == ACCESS) ? wait_cnt + 4'd1 : 4'd0;
      own_cpu_q  <= own_cpu_n;
      wr_q       <= wr_n;
      busy       <= busy_d;
      gnt        <= gnt_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_ub_n  <= ub_n_d;
      sram_lb_n  <= lb_n_d;
      sram_dq_oe <= dq_oe_d;
      dbg.ack    <= dbg_ack_d;
      cpu.ack    <= cpu_ack_d;
      if (load) begin
        sram_addr   <= {2'b00, (sel_cpu ? cpu.addr[15:1] : dbg.addr[15:1])};
        sram_dq_out <= sel_cpu ? cpu.wdata : dbg.wdata;
      end
      if (capture) begin
        if (own_cpu_q) cpu.rdata <= sram_dq_in;
        else           dbg.rdata <= sram_dq_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    be_q <= be_n;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import b16_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [1:0]  gnt;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in = 16'h0;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  int          errors = 0;
  int          checks = 0;

  sram_arbiter_if dbg_if ();
  sram_arbiter_if cpu_if ();

  sram_arbiter #(.WAIT(3), .STARVE(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .dbg         (dbg_if),
    .cpu         (cpu_if),
    .busy        (busy),
    .gnt         (gnt),
    .sram_addr   (sram_addr),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

  always #5 clk = ~clk;

  task automatic clear_ports();
    dbg_if.req = 0; dbg_if.addr = 0; dbg_if.r = 0; dbg_if.w = 0; dbg_if.wdata = 0;
    cpu_if.req = 0; cpu_if.addr = 0; cpu_if.r = 0; cpu_if.w = 0; cpu_if.wdata = 0;
  endtask

  // Cycle c is observed #1 after the c-th rising edge following the request.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_read();
    logic exp_oe, exp_ack;
    @(negedge clk);
    cpu_if.req = 1; cpu_if.r = 1; cpu_if.addr = 16'h1234; sram_dq_in = 16'hBEEF;
    for (int c = 1; c <= 7; c++) begin
      step();
      exp_oe  = !(c >= 1 && c <= 4);
      exp_ack = (c == 5);
      checks++; if (sram_oe_n !== exp_oe) begin errors++; $display("FAIL cpu_rd_oe_n c=%0d got=%b exp=%b", c, sram_oe_n, exp_oe); end
      checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL cpu_rd_we_n c=%0d got=%b exp=1", c, sram_we_n); end
      checks++; if (cpu_if.ack !== exp_ack) begin errors++; $display("FAIL cpu_rd_ack c=%0d got=%b exp=%b", c, cpu_if.ack, exp_ack); end
      checks++; if (dbg_if.ack !== 1'b0) begin errors++; $display("FAIL cpu_rd_dbg_ack c=%0d got=%b exp=0", c, dbg_if.ack); end
      if (c == 1) begin
        checks++; if (sram_addr !== 18'h0091A) begin errors++; $display("FAIL cpu_rd_addr got=%h exp=0091a", sram_addr); end
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL cpu_rd_gnt got=%b exp=10", gnt); end
        checks++; if ({sram_ub_n, sram_lb_n} !== 2'b00) begin errors++; $display("FAIL cpu_rd_lanes got=%b exp=00", {sram_ub_n, sram_lb_n}); end
      end
      if (c == 5) begin
        checks++; if (cpu_if.rdata !== 16'hBEEF) begin errors++; $display("FAIL cpu_rd_rdata got=%h exp=beef", cpu_if.rdata); end
        checks++; if (sram_ce_n !== 1'b0) begin errors++; $display("FAIL cpu_rd_done_ce_n got=%b exp=0", sram_ce_n); end
        cpu_if.req = 0; cpu_if.r = 0;
      end
      if (c == 6) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cpu_rd_idle_busy got=%b exp=0", busy); end
      end
    end
  endtask

  task automatic test_dbg_write();
    logic exp_we, exp_oe, exp_ack;
    @(negedge clk);
    dbg_if.req = 1; dbg_if.addr = 16'h0042; dbg_if.w = 2'b01; dbg_if.wdata = 16'hA55A;
    for (int c = 1; c <= 6; c++) begin
      step();
      exp_we  = !(c >= 2 && c <= 4);
      exp_oe  = (c >= 1 && c <= 5);
      exp_ack = (c == 5);
      checks++; if (sram_we_n !== exp_we) begin errors++; $display("FAIL dbg_wr_we_n c=%0d got=%b exp=%b", c, sram_we_n, exp_we); end
      checks++; if (sram_dq_oe !== exp_oe) begin errors++; $display("FAIL dbg_wr_dq_oe c=%0d got=%b exp=%b", c, sram_dq_oe, exp_oe); end
      checks++; if (dbg_if.ack !== exp_ack) begin errors++; $display("FAIL dbg_wr_ack c=%0d got=%b exp=%b", c, dbg_if.ack, exp_ack); end
      checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL dbg_wr_oe_n c=%0d got=%b exp=1", c, sram_oe_n); end
      if (c >= 1 && c <= 5) begin
        checks++; if ({sram_ub_n, sram_lb_n} !== 2'b10) begin errors++; $display("FAIL dbg_wr_lanes c=%0d got=%b exp=10", c, {sram_ub_n, sram_lb_n}); end
      end
      if (c == 1) begin
        checks++; if (sram_addr !== 18'h00021) begin errors++; $display("FAIL dbg_wr_addr got=%h exp=00021", sram_addr); end
        checks++; if (sram_dq_out !== 16'hA55A) begin errors++; $display("FAIL dbg_wr_dq_out got=%h exp=a55a", sram_dq_out); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL dbg_wr_gnt got=%b exp=01", gnt); end
      end
      if (c == 5) begin dbg_if.req = 0; dbg_if.w = 0; end
      if (c == 6) begin
        checks++; if (cpu_if.rdata !== 16'hBEEF) begin errors++; $display("FAIL dbg_wr_cpu_rdata_held got=%h exp=beef", cpu_if.rdata); end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    step();
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin errors++; $display("FAIL rst_strobes got=%b exp=11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL rst_dq_oe got=%b exp=0", sram_dq_oe); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", sram_addr); end
    checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL rst_dq_out got=%h exp=0", sram_dq_out); end
    checks++; if (cpu_if.rdata !== 16'h0) begin errors++; $display("FAIL rst_cpu_rdata got=%h exp=0", cpu_if.rdata); end
    checks++; if (dbg_if.rdata !== 16'h0) begin errors++; $display("FAIL rst_dbg_rdata got=%h exp=0", dbg_if.rdata); end
    checks++; if ({dbg_if.ack, cpu_if.ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got=%b exp=00", {dbg_if.ack, cpu_if.ack}); end
    checks++; if ({busy, gnt} !== 3'b000) begin errors++; $display("FAIL rst_busy_gnt got=%b exp=000", {busy, gnt}); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=0", dut.state); end
    checks++; if (dut.u_sel.starve_cnt !== 0) begin errors++; $display("FAIL rst_starve got=%0d exp=0", dut.u_sel.starve_cnt); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_both();
    logic exp_dack, exp_cack;
    @(negedge clk);
    dbg_if.req = 1; dbg_if.r = 1; dbg_if.addr = 16'h0010;
    cpu_if.req = 1; cpu_if.r = 1; cpu_if.addr = 16'h0020;
    sram_dq_in = 16'h1111;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_dack = (c == 5);
      exp_cack = (c == 11);
      checks++; if (dbg_if.ack !== exp_dack) begin errors++; $display("FAIL both_dbg_ack c=%0d got=%b exp=%b", c, dbg_if.ack, exp_dack); end
      checks++; if (cpu_if.ack !== exp_cack) begin errors++; $display("FAIL both_cpu_ack c=%0d got=%b exp=%b", c, cpu_if.ack, exp_cack); end
      if (c == 1) begin
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL both_gnt_first got=%b exp=01", gnt); end
        checks++; if (sram_addr !== 18'h00008) begin errors++; $display("FAIL both_addr_first got=%h exp=00008", sram_addr); end
      end
      if (c == 5) begin
        checks++; if (dbg_if.rdata !== 16'h1111) begin errors++; $display("FAIL both_dbg_rdata got=%h exp=1111", dbg_if.rdata); end
        dbg_if.req = 0; dbg_if.r = 0; sram_dq_in = 16'h2222;
      end
      if (c == 6) begin
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL both_gnt_idle got=%b exp=00", gnt); end
      end
      if (c == 7) begin
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL both_gnt_second got=%b exp=10", gnt); end
        checks++; if (sram_addr !== 18'h00010) begin errors++; $display("FAIL both_addr_second got=%h exp=00010", sram_addr); end
      end
      if (c == 11) begin
        checks++; if (cpu_if.rdata !== 16'h2222) begin errors++; $display("FAIL both_cpu_rdata got=%h exp=2222", cpu_if.rdata); end
        checks++; if (dbg_if.rdata !== 16'h1111) begin errors++; $display("FAIL both_dbg_rdata_held got=%h exp=1111", dbg_if.rdata); end
        cpu_if.req = 0; cpu_if.r = 0;
      end
    end
  endtask

  task automatic test_starve();
    int dbg_acks = 0;
    int cpu_acks = 0;
    @(negedge clk);
    dbg_if.req = 1; dbg_if.r = 1; dbg_if.addr = 16'h0100;
    cpu_if.req = 1; cpu_if.r = 1; cpu_if.addr = 16'h0200;
    for (int c = 1; c <= 36; c++) begin
      step();
      if (c <= 29 && dbg_if.ack === 1'b1) dbg_acks++;
      if (cpu_if.ack === 1'b1) cpu_acks++;
      case (c)
        1, 7, 13, 19: begin
          checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL starve_gnt c=%0d got=%b exp=01", c, gnt); end
          checks++; if (dut.u_sel.starve_cnt !== (c / 6 + 1)) begin errors++; $display("FAIL starve_cnt c=%0d got=%0d exp=%0d", c, dut.u_sel.starve_cnt, c / 6 + 1); end
        end
        25: begin
          checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL starve_cpu_gnt got=%b exp=10", gnt); end
          checks++; if (dut.u_sel.starve_cnt !== 0) begin errors++; $display("FAIL starve_cnt_clear got=%0d exp=0", dut.u_sel.starve_cnt); end
        end
        29: begin
          checks++; if (cpu_if.ack !== 1'b1) begin errors++; $display("FAIL starve_cpu_ack got=%b exp=1", cpu_if.ack); end
          cpu_if.req = 0; cpu_if.r = 0;
        end
        31: begin
          checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL starve_dbg_regnt got=%b exp=01", gnt); end
          checks++; if (dut.u_sel.starve_cnt !== 0) begin errors++; $display("FAIL starve_cnt_nocpu got=%0d exp=0", dut.u_sel.starve_cnt); end
          dbg_if.req = 0; dbg_if.r = 0;
        end
        36: begin
          checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_end_busy got=%b exp=0", busy); end
        end
        default: ;
      endcase
    end
    checks++; if (dbg_acks != 4) begin errors++; $display("FAIL starve_dbg_acks got=%0d exp=4", dbg_acks); end
    checks++; if (cpu_acks != 1) begin errors++; $display("FAIL starve_cpu_acks got=%0d exp=1", cpu_acks); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dbg_if.req = 1; dbg_if.addr = 16'h0300; dbg_if.w = 2'b11; dbg_if.wdata = 16'h5A5A;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 3) begin
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rmid_we_active got=%b exp=0", sram_we_n); end
        reset = 1;
      end
      if (c == 4) begin
        checks++; if ({sram_we_n, sram_ce_n, sram_dq_oe} !== 3'b110) begin errors++; $display("FAIL rmid_strobes got=%b exp=110", {sram_we_n, sram_ce_n, sram_dq_oe}); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rmid_state got=%0d exp=0", dut.state); end
        reset = 0; dbg_if.req = 0; dbg_if.w = 0;
      end
      if (c >= 4) begin
        checks++; if (dbg_if.ack !== 1'b0) begin errors++; $display("FAIL rmid_no_ack c=%0d got=%b exp=0", c, dbg_if.ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy c=%0d got=%b exp=0", c, busy); end
      end
    end
  endtask

  task automatic test_null_req();
    @(negedge clk);
    dbg_if.req = 1; dbg_if.r = 0; dbg_if.w = 2'b00;
    cpu_if.req = 1; cpu_if.r = 0; cpu_if.w = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++; if ({busy, gnt} !== 3'b000) begin errors++; $display("FAIL null_busy_gnt c=%0d got=%b exp=000", c, {busy, gnt}); end
      checks++; if (sram_ce_n !== 1'b1) begin errors++; $display("FAIL null_ce_n c=%0d got=%b exp=1", c, sram_ce_n); end
    end
    clear_ports();
  endtask

  initial begin
    clear_ports();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    test_cpu_read();
    test_dbg_write();
    test_reset();
    test_both();
    test_starve();
    test_reset_mid();
    test_null_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
